// File: rtl/sample_serializer_if.sv
// Sample-in / I2S-out signal bundle for sample_serializer.
// master = sample producer (and I2S observer), slave = serializer.
// in_ready is the only backpressure signal; the serial side is free-running.
interface sample_serializer_if;
  logic [23:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        bclk;
  logic        lrclk;
  logic        sdata;

  modport master (output in_data, in_valid, input in_ready, bclk, lrclk, sdata);
  modport slave  (input in_data, in_valid, output in_ready, bclk, lrclk, sdata);
endinterface

// File: rtl/sample_serializer.sv
// Buffers 24-bit samples and shifts them out MSB-first as an I2S stereo stream.
// Latency: a sample leaves at the next slot of its channel (slot = SLOT_BITS bclks).
// Backpressure: in_ready = !full; samples offered while full are dropped (overflow).
module sample_serializer #(
  parameter int BCLK_DIV   = 4,
  parameter int SLOT_BITS  = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        on,
  sample_serializer_if.slave          sif,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        underrun,
  output logic                        overflow
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int BIT_W = $clog2(2 * SLOT_BITS);

  // Each entry carries the channel tag (0 = L, 1 = R) above the sample.
  logic [24:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             wr_tag;
  logic [24:0]      head;

  logic [DIV_W-1:0] div_cnt;
  logic [BIT_W-1:0] bit_cnt, nxt_bit, nxt_j;
  logic             bclk_q, lrclk_q, sdata_q;
  // Holds the 23 bits still to be sent after the MSB; zeros shift in behind them,
  // which produces the trailing pad bits of the slot.
  logic [22:0]      shreg;

  logic full, empty, div_tc, fall, nxt_ch, nxt_lr, slot_start, pop, push;

  assign sif.in_ready = !full;
  assign sif.bclk     = bclk_q;
  assign sif.lrclk    = lrclk_q;
  assign sif.sdata    = sdata_q;

  // Next-bit position, slot boundary detection and FIFO push/pop decisions.
  always_comb begin
    full       = (level == LVL_W'(FIFO_DEPTH));
    empty      = (level == '0);
    div_tc     = (div_cnt == DIV_W'(BCLK_DIV - 1));
    fall       = div_tc && bclk_q;
    nxt_bit    = (bit_cnt == BIT_W'(2 * SLOT_BITS - 1)) ? '0 : bit_cnt + BIT_W'(1);
    nxt_ch     = (nxt_bit >= BIT_W'(SLOT_BITS));
    nxt_j      = nxt_ch ? nxt_bit - BIT_W'(SLOT_BITS) : nxt_bit;
    // lrclk changes one bit ahead of the slot it names.
    nxt_lr     = (nxt_bit >= BIT_W'(SLOT_BITS - 1)) && (nxt_bit <= BIT_W'(2 * SLOT_BITS - 2));
    slot_start = fall && (nxt_j == '0);
    head       = mem[rd_ptr];
    // A head sample of the wrong channel stays put so the stream realigns.
    pop        = slot_start && !empty && (head[24] == nxt_ch);
    push       = sif.in_valid && on && !reset && !full;
  end

  // Clock divider, slot counter, shifter and FIFO pointers; on=0 acts as a flush.
  always_ff @(posedge clk) begin
    if (reset || !on) begin
      div_cnt <= '0;
      bclk_q  <= 1'b0;
      bit_cnt <= BIT_W'(2 * SLOT_BITS - 1);
      lrclk_q <= 1'b0;
      sdata_q <= 1'b0;
      shreg   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      wr_tag  <= 1'b0;
      level   <= '0;
    end else begin
      div_cnt <= div_tc ? '0 : div_cnt + DIV_W'(1);
      if (div_tc) bclk_q <= ~bclk_q;
      if (fall) begin
        bit_cnt <= nxt_bit;
        lrclk_q <= nxt_lr;
        if (slot_start) begin
          sdata_q <= pop && head[23];
          shreg   <= pop ? head[22:0] : '0;
        end else begin
          sdata_q <= shreg[22];
          shreg   <= {shreg[21:0], 1'b0};
        end
      end
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        wr_tag <= ~wr_tag;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Sample storage; the tag records which channel the sample belongs to.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {wr_tag, sif.in_data};
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      underrun <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (on && slot_start && !pop) underrun <= 1'b1;
      if (on && sif.in_valid && full) overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sample_serializer.sv
// Randomised + directed bench for sample_serializer with a queue-based reference model.
// Model predicts slot contents from frame timing; a monitor rebuilds slots from bclk rises.
// Status outputs are compared every cycle on the falling clk edge.
module tb_sample_serializer;
  localparam int D = 4;
  localparam int S = 32;
  localparam int DEPTH = 4;
  localparam int LW = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic on = 1'b0;
  logic [LW-1:0] level;
  logic underrun, overflow;

  sample_serializer_if sif();

  sample_serializer #(.BCLK_DIV(D), .SLOT_BITS(S), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .on(on), .sif(sif),
    .level(level), .underrun(underrun), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [24:0] mq[$];      // buffered {tag, sample}
  logic [23:0] expq[$];    // word expected in the slot currently being sent
  logic        m_tag = 1'b0;
  int          cyc = 0;    // clk edges since on rose
  logic        m_on = 1'b0;
  logic        m_under = 1'b0;
  logic        m_over = 1'b0;
  int          m_fall;
  logic        m_ch;
  logic [24:0] m_head;
  bit          m_full;

  initial forever begin
    @(posedge clk);
    if (reset || !on) begin
      mq.delete();
      expq.delete();
      m_tag = 1'b0;
      cyc = 0;
      m_on = 1'b0;
      if (reset) begin
        m_under = 1'b0;
        m_over = 1'b0;
      end
    end else begin
      m_full = (mq.size() == DEPTH);
      m_on = 1'b1;
      cyc++;
      // bclk falls every 2*D edges; every S-th fall begins a slot, channels alternate.
      if (cyc % (2 * D) == 0) begin
        m_fall = cyc / (2 * D) - 1;
        if (m_fall % S == 0) begin
          m_ch = ((m_fall / S) % 2) == 1;
          if (mq.size() > 0 && mq[0][24] == m_ch) begin
            m_head = mq.pop_front();
            expq.push_back(m_head[23:0]);
          end else begin
            expq.push_back(24'h0);
            m_under = 1'b1;
          end
        end
      end
      if (sif.in_valid) begin
        if (m_full) m_over = 1'b1;
        else begin
          mq.push_back({m_tag, sif.in_data});
          m_tag = ~m_tag;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  int          rise_n = 0;
  int          mj, mslot;
  logic        prev_b = 1'b0;
  logic [S-1:0] word = '0;
  logic [23:0] e;
  logic        exp_lr;

  initial forever begin
    @(negedge clk);
    chk("level", {29'd0, level}, mq.size());
    chk("in_ready", {31'd0, sif.in_ready}, {31'd0, mq.size() < DEPTH});
    chk("underrun", {31'd0, underrun}, {31'd0, m_under});
    chk("overflow", {31'd0, overflow}, {31'd0, m_over});
    chk("bclk", {31'd0, sif.bclk}, m_on ? (cyc / D) % 2 : 0);
    if (!m_on) begin
      chk("lrclk_idle", {31'd0, sif.lrclk}, 32'd0);
      chk("sdata_idle", {31'd0, sif.sdata}, 32'd0);
      rise_n = 0;
      prev_b = 1'b0;
    end else begin
      if (!prev_b && sif.bclk) begin
        if (rise_n == 0) begin
          chk("pre_slot_lrclk", {31'd0, sif.lrclk}, 32'd0);
          chk("pre_slot_sdata", {31'd0, sif.sdata}, 32'd0);
        end else begin
          mj = (rise_n - 1) % S;
          mslot = (rise_n - 1) / S;
          exp_lr = ((mslot % 2) == 1) ^ (mj == S - 1);
          chk("lrclk", {31'd0, sif.lrclk}, {31'd0, exp_lr});
          word = {word[S-2:0], sif.sdata};
          if (mj == S - 1) begin
            if (expq.size() == 0) begin
              n_cmp++;
              n_fail++;
              $display("FAIL slot_expected act=slot_seen exp=no_slot t=%0t", $time);
            end else begin
              e = expq.pop_front();
              chk("slot", word, {e, 8'h00});
            end
          end
        end
        rise_n++;
      end
      prev_b = sif.bclk;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic v, input logic [23:0] d);
    @(posedge clk); #1;
    sif.in_valid = v;
    sif.in_data = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 24'h0);
  endtask

  task automatic set_on(input logic v);
    @(posedge clk); #1;
    on = v;
    sif.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    on = 1'b0;
    sif.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    sif.in_valid = 1'b0;
    sif.in_data = 24'h0;
    do_reset();

    // Two samples before the first slot: L=800001, R=7FFFFF.
    set_on(1'b1);
    step(1'b1, 24'h800001);
    step(1'b1, 24'h7FFFFF);
    idle(2 * S * 2 * D + 40);

    // Running with nothing buffered.
    do_reset();
    set_on(1'b1);
    idle(600);

    // Five back-to-back pushes into a 4-deep FIFO.
    do_reset();
    set_on(1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 24'h100000 + 24'(i));
    idle(1200);

    // Left underrun, then an L sample: the right slot must not steal it.
    do_reset();
    set_on(1'b1);
    idle(20);
    step(1'b1, 24'hA5A5A5);
    idle(1200);

    // Push in the very cycle of the first pop while two are buffered.
    do_reset();
    set_on(1'b1);
    step(1'b1, 24'h123456);
    step(1'b1, 24'h654321);
    idle(4);
    step(1'b1, 24'hC0FFEE);
    idle(1100);

    // Drop on around bit 10 of a left slot with three samples waiting.
    do_reset();
    set_on(1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 24'h0F0F00 + 24'(i));
    idle(84);
    set_on(1'b0);
    idle(20);
    set_on(1'b1);
    idle(300);

    // Random traffic around the nominal two-samples-per-frame rate.
    do_reset();
    set_on(1'b1);
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(0, 3999) == 0) begin
        set_on(1'b0);
        idle($urandom_range(1, 8));
        set_on(1'b1);
      end else begin
        step($urandom_range(0, 255) == 0, 24'($urandom));
      end
    end

    set_on(1'b0);
    idle(10);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
